kw11l_clk: RTL and testbench

- Full KW11L line-time clock for the PDP-11 I/O page.
- A parametrised divider, or a synchronised external line-frequency input, produces ticks. Each tick sets the CSR monitor bit and, when enabled, raises an interrupt request toward the bus arbiter.
- Drops into the iopage decode mux alongside the other *_regs blocks and replaces the stub clock register.

---
 rtl/pdp11_iopage_pkg.sv | 24 ++
 rtl/kw11l_clk_tick_gen.sv | 54 +++++
 rtl/kw11l_clk.sv | 88 ++++++++
 tb/tb_kw11l_clk.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pdp11_iopage_pkg.sv
// Shared PDP-11 I/O page constants and CSR helpers for the peripheral *_regs blocks.
package pdp11_iopage_pkg;

    localparam logic [12:0] KW11L_CSR = 13'o17546;
    localparam logic [7:0]  KW11L_VEC = 8'o100;

    localparam int CSR_DONE = 7;
    localparam int CSR_IE   = 6;

    typedef struct packed {
        logic mon;
        logic ie;
    } kw11l_csr_t;

    // Places the two live CSR bits at their I/O-page positions; all others read 0.
    function automatic logic [15:0] csr_word(input kw11l_csr_t c);
        logic [15:0] w;
        w           = '0;
        w[CSR_DONE] = c.mon;
        w[CSR_IE]   = c.ie;
        return w;
    endfunction

endpackage

// File: rtl/kw11l_clk_tick_gen.sv
// Line-time tick source: free-running divider, or a synchronised external
// line-frequency input, selected at elaboration by EXT_TICK.
module tick_gen #(
    parameter bit          EXT_TICK  = 1'b0,
    parameter int unsigned DIV_WIDTH = 24,
    parameter int unsigned TICK_DIV  = 833333
) (
    input  logic clk,
    input  logic rst,
    input  logic line_tick,
    output logic tick
);

    localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(TICK_DIV - 1);

    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 edge_q, edge_d;

    always_comb begin
        div_d   = '0;
        sync1_d = 1'b0;
        sync2_d = 1'b0;
        edge_d  = 1'b0;
        tick    = 1'b0;
        if (EXT_TICK) begin
            // Two synchroniser flops, then the edge register remembers the
            // previous synchronised level so each rising edge ticks once.
            sync1_d = line_tick;
            sync2_d = sync1_q;
            edge_d  = sync2_q;
            tick    = sync2_q & ~edge_q;
        end else begin
            tick  = (div_q == DIV_LAST);
            div_d = tick ? '0 : div_q + DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            div_q   <= div_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            edge_q  <= edge_d;
        end
    end

endmodule

// File: rtl/kw11l_clk.sv
// KW11L line-time clock: CSR at CSR_ADDR with monitor/IE bits and a single
// held interrupt request toward the bus arbiter.
module kw11l_clk
    import pdp11_iopage_pkg::*;
#(
    parameter logic [12:0] CSR_ADDR  = KW11L_CSR,
    parameter logic [7:0]  VECTOR    = KW11L_VEC,
    parameter bit          EXT_TICK  = 1'b0,
    parameter int unsigned DIV_WIDTH = 24,
    parameter int unsigned TICK_DIV  = 833333
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [12:0] iopage_addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        decode,
    input  logic        iopage_rd,
    input  logic        iopage_wr,
    input  logic        iopage_byte_op,
    input  logic        line_tick,
    output logic        interrupt,
    input  logic        interrupt_ack,
    output logic [7:0]  vector
);

    kw11l_csr_t csr_q, csr_d;
    logic       pend_q, pend_d;
    logic       tick;
    logic       write_en;
    logic       mon_wr;

    // Reads have no side effects, so the read strobe and upper data bits are not needed.
    logic unused_inputs;
    assign unused_inputs = ^{iopage_rd, data_in[15:8], data_in[5:0]};

    tick_gen #(
        .EXT_TICK  (EXT_TICK),
        .DIV_WIDTH (DIV_WIDTH),
        .TICK_DIV  (TICK_DIV)
    ) u_tick (
        .clk       (clk),
        .rst       (reset),
        .line_tick (line_tick),
        .tick      (tick)
    );

    assign decode    = (iopage_addr[12:1] == CSR_ADDR[12:1]);
    assign data_out  = decode ? csr_word(csr_q) : 16'b0;
    assign interrupt = pend_q;
    assign vector    = VECTOR;

    // Odd-byte writes land on the unused high byte and are dropped.
    assign write_en = decode & iopage_wr & (~iopage_byte_op | ~iopage_addr[0]);

    always_comb begin
        csr_d  = csr_q;
        pend_d = pend_q;
        mon_wr = csr_q.mon;

        if (write_en) begin
            csr_d.ie = data_in[CSR_IE];
            mon_wr   = data_in[CSR_DONE] & csr_q.mon;
        end
        csr_d.mon = mon_wr | tick;

        // Later assignments win: ack < tick/IE-rise < IE clear.
        if (interrupt_ack)
            pend_d = 1'b0;
        if (tick && csr_q.ie)
            pend_d = 1'b1;
        if (write_en && data_in[CSR_IE] && !csr_q.ie && csr_d.mon)
            pend_d = 1'b1;
        if (write_en && !data_in[CSR_IE])
            pend_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csr_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            csr_q  <= csr_d;
            pend_q <= pend_d;
        end
    end

endmodule

// File: tb/tb_kw11l_clk.sv
// Directed bench: one internal-divider instance (TICK_DIV=4) and one
// external-line instance sharing the bus inputs.
module tb_kw11l_clk;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] addr = 13'o17546;
    logic [15:0] din = 16'b0;
    logic        rd = 1'b1;
    logic        wr = 1'b0;
    logic        byte_op = 1'b0;
    logic        line = 1'b0;
    logic        ack = 1'b0;

    logic [15:0] dout_i, dout_e;
    logic        dec_i, dec_e, int_i, int_e;
    logic [7:0]  vec_i, vec_e;

    int total = 0;
    int bad   = 0;
    int ext_ticks = 0;
    int snap;

    always #5 clk = ~clk;

    kw11l_clk #(.TICK_DIV(4)) u_int (
        .clk(clk), .reset(rst), .iopage_addr(addr), .data_in(din), .data_out(dout_i),
        .decode(dec_i), .iopage_rd(rd), .iopage_wr(wr), .iopage_byte_op(byte_op),
        .line_tick(line), .interrupt(int_i), .interrupt_ack(ack), .vector(vec_i)
    );

    kw11l_clk #(.EXT_TICK(1'b1), .TICK_DIV(4)) u_ext (
        .clk(clk), .reset(rst), .iopage_addr(addr), .data_in(din), .data_out(dout_e),
        .decode(dec_e), .iopage_rd(rd), .iopage_wr(wr), .iopage_byte_op(byte_op),
        .line_tick(line), .interrupt(int_e), .interrupt_ack(ack), .vector(vec_e)
    );

    always @(posedge clk) if (u_ext.tick) ext_ticks <= ext_ticks + 1;

    typedef struct {
        logic [12:0] addr;
        logic [15:0] din;
        logic        byte_op;
        logic        exp_dec;
        logic [15:0] exp_csr;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0o want %0o", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write(input logic [12:0] a, input logic [15:0] d, input logic b);
        addr = a; din = d; byte_op = b; wr = 1'b1;
        step();
        wr = 1'b0; byte_op = 1'b0; addr = 13'o17546;
    endtask

    initial begin
        tbl[0] = '{13'o17546, 16'o000100, 1'b0, 1'b1, 16'o000100};
        tbl[1] = '{13'o17547, 16'o000377, 1'b1, 1'b1, 16'o000100};
        tbl[2] = '{13'o17546, 16'o000000, 1'b1, 1'b1, 16'o000000};
        tbl[3] = '{13'o17546, 16'o000100, 1'b1, 1'b1, 16'o000100};
        tbl[4] = '{13'o17544, 16'o000000, 1'b0, 1'b0, 16'o000100};
        tbl[5] = '{13'o17550, 16'o000000, 1'b0, 1'b0, 16'o000100};
        tbl[6] = '{13'o17547, 16'o000000, 1'b0, 1'b1, 16'o000000};
        tbl[7] = '{13'o17546, 16'hffff,   1'b0, 1'b1, 16'o000100};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_dout", dout_i, 16'o0);
        check("rst_int", {15'b0, int_i}, 16'd0);
        check("rst_vec", {8'b0, vec_i}, 16'o100);
        rst = 1'b0;

        // Internal divider, IE=0: ticks on edges 4 and 8
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("div_tick_%0d", k), {15'b0, u_int.tick}, {15'b0, (k % 4) == 3});
            check($sformatf("div_noint_%0d", k), {15'b0, int_i}, 16'd0);
            if (k == 3) check("mon_before_tick", dout_i, 16'o0);
            if (k == 4) check("mon_after_tick", dout_i, 16'o200);
        end
        check("read_200", dout_i, 16'o200);

        write(13'o17546, 16'o000100, 1'b0);                 // edge 11
        check("ie_no_int_yet", {15'b0, int_i}, 16'd0);
        step();                                             // edge 12: tick
        check("tick_int", {15'b0, int_i}, 16'd1);
        check("tick_vec", {8'b0, vec_i}, 16'o100);
        ack = 1'b1; step(); ack = 1'b0;                     // edge 13
        check("ack_clears", {15'b0, int_i}, 16'd0);
        check("read_300", dout_i, 16'o300);

        write(13'o17546, 16'o000000, 1'b0);                 // edge 14
        write(13'o17546, 16'o000200, 1'b0);                 // edge 15
        check("cant_set_mon", dout_i, 16'o0);
        step();                                             // edge 16: tick
        check("mon_set_again", dout_i, 16'o200);
        write(13'o17546, 16'o000300, 1'b0);                 // edge 17
        check("ie_rise_int", {15'b0, int_i}, 16'd1);
        check("ie_rise_csr", dout_i, 16'o300);

        step(); step();                                     // edges 18,19
        ack = 1'b1; step(); ack = 1'b0;                     // edge 20: ack + tick
        check("ack_tick_int", {15'b0, int_i}, 16'd1);
        step(); step(); step();                             // edges 21..23
        check("int_held", {15'b0, int_i}, 16'd1);
        write(13'o17546, 16'o000000, 1'b0);                 // edge 24: clear + tick
        check("ieclr_tick_int", {15'b0, int_i}, 16'd0);
        check("ieclr_tick_csr", dout_i, 16'o200);

        // Table: decode and byte/word writes on the external-mode instance
        rst = 1'b1; #1; rst = 1'b0;
        foreach (tbl[i]) begin
            addr = tbl[i].addr; din = tbl[i].din; byte_op = tbl[i].byte_op; wr = 1'b1;
            #1;
            check($sformatf("tbl_dec_%0d", i), {15'b0, dec_e}, {15'b0, tbl[i].exp_dec});
            step();
            wr = 1'b0; byte_op = 1'b0; addr = 13'o17546;
            #1;
            check($sformatf("tbl_csr_%0d", i), dout_e, tbl[i].exp_csr);
        end
        addr = 13'o17544; #1;
        check("nodec_dout", dout_e, 16'o0);
        addr = 13'o17546;
        @(negedge clk);

        // External line: tick lands on the 3rd edge after the rise
        rst = 1'b1; step(); rst = 1'b0;
        write(13'o17546, 16'o000100, 1'b0);
        line = 1'b1;
        step();
        check("ext_e1_tick", {15'b0, u_ext.tick}, 16'd0);
        check("ext_e1_csr", dout_e, 16'o100);
        step();
        check("ext_e2_tick", {15'b0, u_ext.tick}, 16'd1);
        check("ext_e2_csr", dout_e, 16'o100);
        step();
        check("ext_e3_tick", {15'b0, u_ext.tick}, 16'd0);
        check("ext_e3_csr", dout_e, 16'o300);
        check("ext_e3_int", {15'b0, int_e}, 16'd1);
        ack = 1'b1; step(); ack = 1'b0;
        repeat (5) step();
        check("ext_hold_noint", {15'b0, int_e}, 16'd0);

        snap = ext_ticks;
        for (int n = 0; n < 3; n++) begin
            line = 1'b0; repeat (6) step();
            line = 1'b1; repeat (6) step();
        end
        check("ext_tick_count", 16'(ext_ticks - snap), 16'd3);
        check("ext_int_again", {15'b0, int_e}, 16'd1);

        // Asynchronous reset drops the request before any clock edge
        #2 rst = 1'b1;
        #1;
        check("async_rst_int", {15'b0, int_e}, 16'd0);
        check("async_rst_csr", dout_e, 16'o0);
        line = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("rst_phase_%0d", k), {15'b0, u_int.tick}, {15'b0, k == 3});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
